// File: rtl/config_chain_loader.sv
// Configuration chain loader: buffers words from the bridge and shifts them LSB first
// into a tile configuration chain, then strobes cfg_set_o once CHAIN_LEN bits are in.
//
// state  | meaning
// IDLE   | armed, chain untouched, waiting for the first word
// SHIFT  | presenting one bit per cycle (stalls while no word is available)
// SET    | one-cycle latch strobe; word buffer flushed on entry
// DONE   | load complete, words refused until start_i
module config_chain_loader #(
   parameter int WORD_W     = 32,
   parameter int CHAIN_LEN  = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_i,
   input  logic                               start_i,
   input  logic [WORD_W-1:0]                  word_i,
   input  logic                               word_valid_i,
   output logic                               word_ready_o,
   output logic                               cfg_data_o,
   output logic                               cfg_shift_o,
   output logic                               cfg_set_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic [$clog2(CHAIN_LEN+1)-1:0]     bits_sent_o
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int REM_W = $clog2(WORD_W + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_SET,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  sr_q, sr_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   bits_q, bits_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [WORD_W-1:0]  fifo_mem_q [FIFO_DEPTH];

   logic fifo_full;
   logic fifo_empty;
   logic accepting;
   logic push;
   logic shifting;
   logic last_chain_bit;
   logic sr_need;
   logic pop_fifo;
   logic bypass;
   logic load;
   logic fifo_wr;

   assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign accepting  = ((state_q == ST_IDLE) || (state_q == ST_SHIFT)) && !fifo_full;
   assign push       = word_valid_i && accepting && !start_i && !wb_rst_i;

   assign shifting       = (state_q == ST_SHIFT) && (rem_q != '0);
   assign last_chain_bit = shifting && (bits_q == CNT_W'(CHAIN_LEN - 1));

   // Reload in the same cycle the last bit of a word goes out, so streams have no gaps.
   // When the buffer is empty an incoming word goes straight into the shift register.
   assign sr_need  = ((state_q == ST_IDLE) || (state_q == ST_SHIFT)) && !last_chain_bit &&
                     ((rem_q == '0) || (shifting && (rem_q == REM_W'(1))));
   assign pop_fifo = sr_need && !fifo_empty;
   assign bypass   = sr_need && fifo_empty && push;
   assign load     = pop_fifo || bypass;
   assign fifo_wr  = push && !bypass;

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      rem_d    = rem_q;
      bits_d   = bits_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q + OCC_W'(fifo_wr) - OCC_W'(pop_fifo);

      if (fifo_wr) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fifo) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (shifting) begin
         sr_d   = sr_q >> 1;
         rem_d  = rem_q - REM_W'(1);
         bits_d = bits_q + CNT_W'(1);
      end
      if (load) begin
         sr_d  = pop_fifo ? fifo_mem_q[rd_ptr_q] : word_i;
         rem_d = REM_W'(WORD_W);
      end

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_chain_bit) begin
               state_d  = ST_SET;
               sr_d     = '0;
               rem_d    = '0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               occ_d    = '0;
            end
         end
         ST_SET: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_i) begin
         state_d  = ST_IDLE;
         sr_d     = '0;
         rem_d    = '0;
         bits_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         rem_q    <= '0;
         bits_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         rem_q    <= rem_d;
         bits_q   <= bits_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (fifo_wr) begin
         fifo_mem_q[wr_ptr_q] <= word_i;
      end
   end

   // Reset forces every output low in the cycle it is asserted as well.
   assign word_ready_o = accepting && !wb_rst_i;
   assign cfg_shift_o  = shifting && !wb_rst_i;
   assign cfg_data_o   = shifting && sr_q[0] && !wb_rst_i;
   assign cfg_set_o    = (state_q == ST_SET) && !wb_rst_i;
   assign busy_o       = ((state_q == ST_SHIFT) || (state_q == ST_SET)) && !wb_rst_i;
   assign done_o       = (state_q == ST_DONE) && !wb_rst_i;
   assign bits_sent_o  = wb_rst_i ? '0 : bits_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: expected chain bits are queued when a word is
// accepted and popped whenever the DUT asserts cfg_shift_o.
module tb_config_chain_loader;

   localparam int WW = 32;
   localparam int CL = 72;
   localparam int FD = 2;
   localparam int BW = $clog2(CL + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          valid;
   logic [WW-1:0] word;
   logic          ready;
   logic          data;
   logic          shift;
   logic          set;
   logic          busy;
   logic          done;
   logic [BW-1:0] bits;

   config_chain_loader #(
      .WORD_W     (WW),
      .CHAIN_LEN  (CL),
      .FIFO_DEPTH (FD)
   ) u_dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .start_i      (start),
      .word_i       (word),
      .word_valid_i (valid),
      .word_ready_o (ready),
      .cfg_data_o   (data),
      .cfg_shift_o  (shift),
      .cfg_set_o    (set),
      .busy_o       (busy),
      .done_o       (done),
      .bits_sent_o  (bits)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   exp_q[$];
   int   push_left;
   int   sent_m;
   int   cyc_n;
   int   first_shift;
   int   last_shift;
   int   set_cyc;
   int   set_cnt;
   int   shift_cnt;
   int   stall_cnt;
   logic mon_shift;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      push_left   = CL;
      sent_m      = 0;
      first_shift = -1;
      last_shift  = -1;
      set_cyc     = -1;
      set_cnt     = 0;
      shift_cnt   = 0;
      stall_cnt   = 0;
   endtask

   // Bits of an accepted word that still fit in the chain; the rest are never shifted.
   task automatic model_accept(input logic [WW-1:0] w);
      for (int i = 0; i < WW && push_left > 0; i++) begin
         exp_q.push_back(w[i]);
         push_left--;
      end
   endtask

   // One clock cycle: sample outputs at the falling edge, then step past the rising edge.
   task automatic cyc();
      @(negedge clk);
      mon_shift = shift;
      if (shift === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("extra_shift", shift, 1'b0);
         end else begin
            check("cfg_data", data, exp_q.pop_front());
         end
         if (first_shift < 0) first_shift = cyc_n;
         last_shift = cyc_n;
         shift_cnt++;
      end else begin
         check("data_when_idle", data, 1'b0);
         if (busy === 1'b1 && set !== 1'b1) stall_cnt++;
      end
      check("bits_sent", bits, rst ? 0 : sent_m);
      if (shift === 1'b1) sent_m++;
      if (set === 1'b1) begin
         set_cnt++;
         set_cyc = cyc_n;
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic send_word(input logic [WW-1:0] w, output int waited, output int acc);
      valid  = 1'b1;
      word   = w;
      waited = 0;
      acc    = -1;
      while (ready !== 1'b1 && waited < 200) begin
         cyc();
         waited++;
      end
      if (ready !== 1'b1) begin
         check("send_timeout", ready, 1'b1);
      end else begin
         model_accept(w);
         acc = cyc_n;
      end
      cyc();
      valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (done !== 1'b1 && guard < 300) begin
         cyc();
         guard++;
      end
      check("done_reached", done, 1'b1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      clear_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int acc0;
      int acc;
      int guard;
      rst   = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      word  = '0;
      cyc_n = 0;
      mon_shift = 1'b0;
      clear_model();
      @(posedge clk);
      #1;

      // Reset
      cyc();
      cyc();
      check("rst_ready", ready, 1'b0);
      check("rst_shift", shift, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_set", set, 1'b0);
      check("rst_bits", bits, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", ready, 1'b1);

      // Back-to-back, backpressure and partial last word
      send_word(32'hFFFF_FFFF, w, acc0);
      check("w0_wait", w, 0);
      send_word(32'h3C5A_9617, w, acc);
      check("w1_wait", w, 0);
      send_word(32'h0000_00AA, w, acc);
      check("w2_wait", w, 0);
      send_word(32'hDEAD_BEEF, w, acc);
      check("full_wait_cycles", w, 30);
      check("first_latency", first_shift, acc0 + 1);
      wait_done();
      check("done_cycle", cyc_n, last_shift + 2);
      check("set_cycle", set_cyc, last_shift + 1);
      check("set_count", set_cnt, 1);
      check("shift_total", shift_cnt, CL);
      check("no_gap", last_shift - first_shift + 1, CL);
      check("queue_drained", exp_q.size(), 0);
      check("done_busy", busy, 1'b0);
      check("done_bits", bits, CL);
      valid = 1'b1;
      word  = 32'h1357_9BDF;
      for (int i = 0; i < 4; i++) begin
         check("done_refuse", ready, 1'b0);
         cyc();
      end
      valid = 1'b0;
      check("done_held", done, 1'b1);
      check("done_no_shift", shift_cnt, CL);

      // Source stall
      pulse_start();
      check("rearm_bits", bits, 0);
      check("rearm_done", done, 1'b0);
      check("rearm_ready", ready, 1'b1);
      send_word($urandom(), w, acc);
      guard = 0;
      while (!(shift_cnt > 0 && mon_shift === 1'b0) && guard < 100) begin
         cyc();
         guard++;
      end
      repeat (18) cyc();
      check("stall_bits", bits, 32);
      send_word($urandom(), w, acc);
      send_word($urandom(), w, acc);
      wait_done();
      check("stall_cycles", stall_cnt, 20);
      check("stall_shift_total", shift_cnt, CL);
      check("stall_set_count", set_cnt, 1);
      check("stall_queue", exp_q.size(), 0);

      // Abort mid-load; the word offered alongside start_i must be dropped
      pulse_start();
      send_word($urandom(), w, acc);
      send_word($urandom(), w, acc);
      guard = 0;
      while (bits !== 17 && guard < 100) begin
         cyc();
         guard++;
      end
      check("abort_at_17", bits, 17);
      start = 1'b1;
      valid = 1'b1;
      word  = 32'hBAD0_BAD0;
      cyc();
      start = 1'b0;
      valid = 1'b0;
      clear_model();
      check("abort_bits", bits, 0);
      check("abort_busy", busy, 1'b0);
      check("abort_shift", shift, 1'b0);
      check("abort_ready", ready, 1'b1);
      repeat (5) cyc();
      check("abort_no_set", set_cnt, 0);
      check("abort_no_shift", shift_cnt, 0);
      for (int i = 0; i < 3; i++) send_word($urandom(), w, acc);
      wait_done();
      check("reload_shift_total", shift_cnt, CL);
      check("reload_set_count", set_cnt, 1);
      check("reload_queue", exp_q.size(), 0);

      // Reset mid-shift with a coincident handshake attempt
      pulse_start();
      send_word($urandom(), w, acc);
      repeat (10) cyc();
      rst   = 1'b1;
      valid = 1'b1;
      word  = 32'h0F0F_F0F0;
      #1;
      check("rst_mid_ready", ready, 1'b0);
      check("rst_mid_shift", shift, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      cyc();
      rst   = 1'b0;
      valid = 1'b0;
      clear_model();
      #1;
      check("after_rst_ready", ready, 1'b1);
      check("after_rst_busy", busy, 1'b0);
      check("after_rst_done", done, 1'b0);
      check("after_rst_set", set, 1'b0);
      check("after_rst_bits", bits, 0);
      repeat (5) cyc();
      check("after_rst_no_shift", shift_cnt, 0);
      for (int i = 0; i < 3; i++) send_word($urandom(), w, acc);
      wait_done();
      check("final_shift_total", shift_cnt, CL);
      check("final_set_count", set_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
